joystick_spi_reader: RTL
========================

// Module: joystick_spi_reader
// PURPOSE
//  SPI master that polls the PmodJSTK joystick and produces the 10-bit Xdata/Ydata
//  words consumed by cursor_logic (which maps them to grid position 0-8).
//  Each poll is one 5-byte SPI mode-0 transaction. It also sends the 2-bit LED
//  command and returns the 3 button bits.
//  Outputs hold the last complete sample and update only when a transaction ends.
// PARAMETERS
//  SCLK_HALF    100        clk cycles per SCLK half-period (100 MHz clk -> 500 kHz SCLK)
//  SS_SETUP     1500       cycles from ss_n falling to the first SCLK rise (15 us)
//  BYTE_GAP     1000       idle cycles between bytes, SCLK low, ss_n low (10 us)
//  POLL_CYC     1000000    cycles spent in IDLE before each transaction (10 ms)
// PORTS
//  clk       in   1   system clock; all logic on the rising edge
//  rst       in   1   synchronous, active-high reset
//  led       in   2   LED command bits; sampled when a transaction starts
//  miso      in   1   joystick serial data out
//  ss_n      out  1   slave select, active low
//  sclk      out  1   SPI clock, idles low
//  mosi      out  1   serial data to joystick, MSB first
//  Xdata     out  10  last X sample, 0..1023
//  Ydata     out  10  last Y sample, 0..1023
//  buttons   out  3   last button bits {btn2, btn1, trigger}
//  valid     out  1   one-cycle pulse when Xdata/Ydata/buttons update
// BEHAVIOUR
//  Reset values: ss_n=1, sclk=0, mosi=0, Xdata=512, Ydata=512, buttons=0, valid=0,
//   state=IDLE, all counters=0. Reset mid-transaction aborts it the same cycle:
//   ss_n returns to 1 and the held outputs return to their reset values.
//  FSM states: IDLE -> SETUP -> SHIFT -> (GAP -> SHIFT)x4 -> DONE -> IDLE.
//  IDLE
//   - Count POLL_CYC cycles.
//   - On the last count: drop ss_n, latch tx byte0 = {6'b100000, led}, go to SETUP.
//  SETUP
//   - Hold SS_SETUP cycles with sclk=0.
//   - Put mosi = tx[7] before leaving; go to SHIFT.
//  SHIFT (mode 0), per bit:
//   - Low phase: SCLK_HALF cycles with sclk=0 and mosi stable.
//   - Rising edge: sclk=1; sample miso into rx[0] (left shift, MSB first).
//   - High phase: SCLK_HALF cycles; at its end set sclk=0 and present the next mosi bit.
//   - After 8 bits: store the byte by index, then go to GAP (bytes 0-3) or DONE (byte 4).
//   - Bytes 1-4 transmit 8'h00.
//  GAP: BYTE_GAP cycles, sclk=0, ss_n=0; mosi = MSB of the next tx byte.
//  Byte map (received):
//   - b0 = X[7:0]; b1[1:0] = X[9:8]
//   - b2 = Y[7:0]; b3[1:0] = Y[9:8]
//   - b4[2:0] = buttons
//   - Upper bits of b1, b3 and b4 are ignored.
//  DONE (1 cycle):
//   - Register Xdata, Ydata and buttons together; pulse valid=1; set ss_n=1, mosi=0.
//   - Go to IDLE with the poll counter cleared.
//  Per transaction: exactly 40 sclk rising edges. ss_n stays low from SETUP to DONE.
//  led changes during a transaction take effect on the next transaction only.
//  miso is assumed already synchronised to clk; this block adds no extra sync stage.
//  Xdata/Ydata never change except in DONE or on reset (no partial updates).
// TESTING (bench uses SCLK_HALF=2, SS_SETUP=6, BYTE_GAP=4, POLL_CYC=20)
//  - Reset:
//     - Hold rst for 5 cycles.
//     - Required: ss_n=1, sclk=0, Xdata=Ydata=512, valid=0.
//     - First ss_n fall occurs exactly 20 cycles after rst is released.
//  - Full sample:
//     - Slave model returns X=1000 (E8, 03), Y=0 (00, 00), buttons 3'b101.
//     - Required: one valid pulse, Xdata=1000, Ydata=0, buttons=5, 40 sclk rises.
//  - LED command:
//     - Drive led=2'b10.
//     - Required: first MOSI byte captured on sclk rises = 8'h82; bytes 1-4 = 8'h00.
//  - Masking:
//     - Slave model returns b1=8'hFF, b3=8'hFE, b4=8'hFF.
//     - Required: X[9:8]=3, Y[9:8]=2, buttons=7; no bit leaks from the upper bits.
//  - Reset mid-transaction:
//     - Assert rst during byte 2.
//     - Required: ss_n=1 and sclk=0 next cycle, outputs back to 512/512/0, no valid pulse.
//     - Next transaction is clean and complete.
//  - Back-to-back polls:
//     - Run 3 transactions with X = 0, 512, 1023.
//     - Required: valid pulses spaced by the constant poll period.
//     - Xdata steps 0 -> 512 -> 1023 and holds between pulses.

Source files
------------

// File: rtl/joystick_spi_reader.sv
// PmodJSTK poller: one 5-byte SPI mode-0 transfer per poll period.
// Holds the last complete X/Y/button sample and pulses valid on update.
module joystick_spi_reader #(
    parameter int SCLK_HALF = 100,
    parameter int SS_SETUP  = 1500,
    parameter int BYTE_GAP  = 1000,
    parameter int POLL_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] Xdata,
    output logic [9:0] Ydata,
    output logic [2:0] buttons,
    output logic       valid
);

    localparam int M1   = (SCLK_HALF > SS_SETUP) ? SCLK_HALF : SS_SETUP;
    localparam int M2   = (M1 > BYTE_GAP) ? M1 : BYTE_GAP;
    localparam int MAXC = (M2 > POLL_CYC) ? M2 : POLL_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BYTE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [2:0]    bytecnt;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [7:0]    x_lo;
    logic [1:0]    x_hi;
    logic [7:0]    y_lo;
    logic [1:0]    y_hi;

    // Transaction sequencer: poll timer, SPI bit engine and sample capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            bytecnt <= '0;
            tx      <= '0;
            rx      <= '0;
            x_lo    <= '0;
            x_hi    <= '0;
            y_lo    <= '0;
            y_hi    <= '0;
            ss_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            Xdata   <= 10'd512;
            Ydata   <= 10'd512;
            buttons <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cnt == POLL_LAST) begin
                        cnt     <= '0;
                        ss_n    <= 1'b0;
                        tx      <= {6'b100000, led};
                        bitcnt  <= '0;
                        bytecnt <= '0;
                        state   <= SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        mosi  <= tx[7];
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (!sclk) begin
                        cnt  <= '0;
                        sclk <= 1'b1;
                        rx   <= {rx[6:0], miso};
                    end else begin
                        cnt    <= '0;
                        sclk   <= 1'b0;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            case (bytecnt)
                                3'd0:    x_lo <= rx;
                                3'd1:    x_hi <= rx[1:0];
                                3'd2:    y_lo <= rx;
                                3'd3:    y_hi <= rx[1:0];
                                default: ;
                            endcase
                            // bytes 1-4 are all-zero on MOSI
                            tx      <= '0;
                            mosi    <= 1'b0;
                            bytecnt <= bytecnt + 1'b1;
                            state   <= (bytecnt == 3'd4) ? DONE : GAP;
                        end else begin
                            tx   <= {tx[6:0], 1'b0};
                            mosi <= tx[6];
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    Xdata   <= {x_hi, x_lo};
                    Ydata   <= {y_hi, y_lo};
                    buttons <= rx[2:0];
                    valid   <= 1'b1;
                    ss_n    <= 1'b1;
                    mosi    <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
